fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares one FIFO write port among NUM_REQ producer streams.
- Each producer uses a valid/ready handshake. The winner's data is tagged with its requester ID and written into the shared FIFO.
- Supports burst lock: a granted requester keeps the port for up to MAX_BURST consecutive beats.
- Sits in front of the MME result/command FIFOs, where several engines drain into one queue.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per requester.
- MAX_BURST, 4, maximum beats per grant before forced rotation (1..256; 1 means pure per-beat round-robin).
- ID_WIDTH, $clog2(NUM_REQ), width of the requester tag (derived; do not override).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- req_valid_i  input  NUM_REQ  per-requester data valid.
- req_data_i  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_full_i  input  1  full flag from the shared FIFO.
- fifo_wren_o  output  1  FIFO write enable.
- fifo_wdata_o  output  ID_WIDTH+DATA_WIDTH  {grant_id, payload}.
- grant_id_o  output  ID_WIDTH  current owner; valid when fifo_wren_o=1.
- busy_o  output  1  1 while in state LOCK.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE, prio_ptr=0, owner=0, beat_cnt=0.
  - Outputs while in reset: req_ready_o=0, fifo_wren_o=0, busy_o=0, grant_id_o=0, fifo_wdata_o=0.
- Transfer rule: a transfer on requester i occurs when req_valid_i[i] & req_ready_o[i]. fifo_wren_o = OR of all transfers. At most one transfer per cycle.
- Latency: the grant is combinational from registered state plus req_valid_i. There is no pipeline; payload reaches the FIFO write port in the same cycle.
- Readiness: req_ready_o[i] = grant[i] & ~fifo_full_i. The FIFO full flag is registered and already accounts for the write in the cycle it asserts, so writing whenever full=0 never overflows.
- Overflow guard: fifo_wren_o must never assert while fifo_full_i=1. This is checked by assertion.
- State IDLE:
  - grant = first valid requester scanning prio_ptr, prio_ptr+1, ... modulo NUM_REQ.
  - On a transfer by requester g: owner=g, beat_cnt=1, prio_ptr=(g+1) mod NUM_REQ.
  - If MAX_BURST>1, go to LOCK; otherwise stay in IDLE.
  - With no transfer (nothing valid, or full), state is unchanged and no grant is latched.
- State LOCK:
  - Grant is forced to owner only, even if other requesters are valid and the owner is not.
  - Owner transfer with beat_cnt+1 == MAX_BURST: go to IDLE, beat_cnt=0.
  - Owner transfer otherwise: beat_cnt++.
  - Owner req_valid_i=0 (no transfer): go to IDLE immediately, that cycle, releasing the lock.
  - fifo_full_i=1 while the owner is valid: hold LOCK and beat_cnt, with no timeout.
- Wrap-around:
  - prio_ptr wraps from NUM_REQ-1 to 0.
  - beat_cnt is wide enough for MAX_BURST and never wraps.
- Simultaneous events:
  - Release cycle: on the cycle the owner's lock releases because it dropped valid, no new grant is issued. Arbitration restarts in IDLE on the next cycle.
  - Final-beat cycle: on the cycle of the final burst beat, only that beat transfers.
- Mid-operation reset: a reset mid-burst aborts the burst with no write in the reset cycle. Arbitration restarts from requester 0.
- Payload stability: requesters must hold valid and data stable until accepted. The arbiter does not check this.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum typedef (IDLE, LOCK);
  - a function computing ID_WIDTH from NUM_REQ;
  - a function for round-robin next-index.
- Sub-module rr_pick: a purely combinational rotating priority encoder. Inputs are a request vector and prio_ptr; outputs are a one-hot grant and a grant index. It is reusable by the read-side scheduler.
- The arbiter top instantiates rr_pick and contains the FSM and counters. The bench connects it to the existing FIFO, with DEPTH_LG2=2.

Test Plan (all with NUM_REQ=4, MAX_BURST=4 unless stated):
- Single requester: after reset, req 2 presents 0xA0..0xA5 continuously. Expect FIFO writes A0..A3 tagged id=2. IDLE is then entered for one cycle of re-arbitration, then A4,A5. Read-out order is exact.
- Round-robin fairness: all 4 valid constantly and FIFO drained every cycle, MAX_BURST=1. Expect write IDs 0,1,2,3,0,1,... with no gaps.
- Burst lock versus competitor: req 0 is valid for 6 beats and req 1 is valid throughout. Expect ids 0,0,0,0,1,1,1,1,0,0. Req 1 is never granted mid-burst.
- Backpressure: FIFO depth 4 with no reads, and req 3 sends 0x10..0x15. Expect 4 writes, then fifo_wren_o=0 and req_ready_o=0 while full, and no overflow message. Enable reads and expect 0x14,0x15 to follow in order.
- Early release: req 1 sends 2 beats then drops valid while req 2 is valid. Expect LOCK exited that cycle, one idle cycle, then req 2 granted with busy_o=1.
- Reset mid-burst: assert rst_n=0 after 2 beats of req 3. Expect no write that cycle and all outputs 0. After release with reqs 0 and 3 valid, expect id 0 first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared state type and index helpers for the FIFO write-port arbiter and its picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int num_req);
        return (idx + 1 >= num_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO, show-ahead read data, registered full/empty flags.
// Latency: an accepted write is visible on rd_data on the following cycle.
// Backpressure: full rises on the edge that fills the last slot; writes while full are dropped.
module fifo_sync #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int DEPTH = 1 << DEPTH_LG2;
    localparam logic [DEPTH_LG2:0] DEPTH_V = {1'b1, {DEPTH_LG2{1'b0}}};

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LG2-1:0] wr_ptr;
    logic [DEPTH_LG2-1:0] rd_ptr;
    logic [DEPTH_LG2:0]   count;
    logic [DEPTH_LG2:0]   count_nxt;
    logic                 wr_ok;
    logic                 rd_ok;

    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + 1'b1;
        end else if (!wr_ok && rd_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_V);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or after prio_ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own ready conditions.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] prio_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = int'(prio_ptr);
        for (int k = 0; k < N; k++) begin
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(idx);
            end
            idx = rr_next(idx, N);
        end
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with burst lock.
// Latency: zero; the winner's payload is presented to the FIFO write port in the same cycle.
// Backpressure: every req_ready_o drops while fifo_full_i is high; a locked burst holds its place.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic                         fifo_full_i,
    output logic                         fifo_wren_o,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wdata_o,
    output logic [ID_WIDTH-1:0]          grant_id_o,
    output logic                         busy_o
);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e          state;
    logic [ID_WIDTH-1:0] prio_ptr;
    logic [ID_WIDTH-1:0] owner;
    logic [BW-1:0]       beat_cnt;

    logic [NUM_REQ-1:0]    pick_grant;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  pick_vld;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [DATA_WIDTH-1:0] payload;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_WIDTH)
    ) u_pick (
        .req       (req_valid_i),
        .prio_ptr  (prio_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    // Reset gates the grant combinationally so a reset cycle never writes.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        if (rst_n) begin
            if (state == IDLE) begin
                if (pick_vld) begin
                    grant    = pick_grant;
                    grant_id = pick_idx;
                end
            end else begin
                grant[owner] = req_valid_i[owner];
                grant_id     = owner;
            end
        end
    end

    assign payload      = req_data_i[int'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
    assign req_ready_o  = grant & {NUM_REQ{~fifo_full_i}};
    assign fifo_wren_o  = |(req_ready_o & req_valid_i);
    assign grant_id_o   = grant_id;
    assign fifo_wdata_o = rst_n ? {grant_id, payload} : '0;
    assign busy_o       = rst_n && (state == LOCK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio_ptr <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_wren_o) begin
                        owner    <= pick_idx;
                        beat_cnt <= BW'(1);
                        prio_ptr <= ID_WIDTH'(rr_next(int'(pick_idx), NUM_REQ));
                        if (MAX_BURST > 1) state <= LOCK;
                    end
                end
                LOCK: begin
                    // Owner dropping valid releases at once; a stall on full keeps the lock.
                    if (!req_valid_i[owner]) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                    end else if (fifo_wren_o) begin
                        if (int'(beat_cnt) + 1 == MAX_BURST) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wren_o && fifo_full_i));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: arbiter (burst 4) feeding a depth-4 FIFO, plus a burst-1 instance for fairness.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int EW = IW + DW;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          fifo_full;
    logic          fifo_wren;
    logic          busy;
    logic [EW-1:0] fifo_wdata;
    logic [IW-1:0] grant_id;
    logic          rd_en = 1'b0;
    logic [EW-1:0] rd_data;
    logic          fifo_empty;

    logic [N-1:0]    f_valid = '0;
    logic [N*DW-1:0] f_data  = '0;
    logic [N-1:0]    f_ready;
    logic            f_full  = 1'b0;
    logic            f_wren;
    logic            f_busy;
    logic [EW-1:0]   f_wdata;
    logic [IW-1:0]   f_gid;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid_i (req_valid), .req_data_i (req_data), .req_ready_o (req_ready),
        .fifo_full_i (fifo_full), .fifo_wren_o (fifo_wren), .fifo_wdata_o (fifo_wdata),
        .grant_id_o (grant_id), .busy_o (busy)
    );

    fifo_sync #(.WIDTH(EW), .DEPTH_LG2(2)) u_fifo (
        .clk (clk), .rst_n (rst_n), .wr_en (fifo_wren), .wr_data (fifo_wdata),
        .rd_en (rd_en), .rd_data (rd_data), .empty (fifo_empty), .full (fifo_full)
    );

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_rr (
        .clk (clk), .rst_n (rst_n),
        .req_valid_i (f_valid), .req_data_i (f_data), .req_ready_o (f_ready),
        .fifo_full_i (f_full), .fifo_wren_o (f_wren), .fifo_wdata_o (f_wdata),
        .grant_id_o (f_gid), .busy_o (f_busy)
    );

    int checks = 0;
    int errors = 0;
    int overflow = 0;
    int cyc = 0;
    int remaining [N];
    logic [DW-1:0] next_val [N];
    logic [N-1:0]  xfer = '0;
    logic rst_req = 1'b0;
    logic rd_req = 1'b1;
    logic fair_req = 1'b0;
    logic rd_chk = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] rd_exp_q[$];
    logic [EW-1:0] fair_q[$];
    logic [31:0] wren_hist = '0;
    logic [31:0] busy_hist = '0;

    function automatic logic [EW-1:0] ent(input int id, input int val);
        return {IW'(id), DW'(val)};
    endfunction

    function automatic bit src_active();
        for (int i = 0; i < N; i++) if (remaining[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        xfer = req_valid & req_ready;
        if (fifo_wren && fifo_full) overflow++;
        if (cyc < 32) begin
            wren_hist[cyc] = fifo_wren;
            busy_hist[cyc] = busy;
        end
        cyc++;
        if (fifo_wren) begin
            chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("wr_dat", 64'(fifo_wdata), 64'(exp_q.pop_front()));
        end
        if (rd_chk && rd_en && !fifo_empty && rd_exp_q.size() != 0)
            chk("rd_dat", 64'(rd_data), 64'(rd_exp_q.pop_front()));
        if (f_valid != '0 && fair_q.size() != 0)
            chk("rr_beat", 64'({f_wren, f_wdata}), 64'({1'b1, fair_q.pop_front()}));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                next_val[i] = next_val[i] + 1;
                remaining[i] = remaining[i] - 1;
            end
        end
        xfer    = '0;
        rst_n   = rst_req;
        rd_en   = rd_req;
        f_valid = fair_req ? '1 : '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (remaining[i] > 0);
            req_data[i*DW +: DW] = next_val[i];
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_until_idle(input int bound, input string tag);
        int n = 0;
        while (src_active() && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < bound), 64'd1);
    endtask

    task automatic start();
        cyc = 0;
        wren_hist = '0;
        busy_hist = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_wren"},  64'(fifo_wren), 64'd0);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_gid"},   64'(grant_id),  64'd0);
        chk({tag, "_wdata"}, 64'(fifo_wdata), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0;
            next_val[i]  = '0;
            f_data[i*DW +: DW] = DW'(32'hC0 + i);
        end

        // Reset with a requester already valid: nothing may leak out.
        remaining[0] = 1;
        next_val[0]  = 32'h77;
        tick();
        tick();
        chk_reset_outputs("rst");
        remaining[0] = 0;
        rst_req = 1'b1;
        settle(3);

        // Single requester: two bursts back to back, re-arbitration in IDLE costs no cycle.
        start();
        remaining[2] = 6;
        next_val[2]  = 32'hA0;
        for (int k = 0; k < 6; k++) exp_q.push_back(ent(2, 32'hA0 + k));
        run_until_idle(40, "t1_done");
        chk("t1_wren_hist", 64'(wren_hist[6:0]), 64'b0111111);
        chk("t1_busy_hist", 64'(busy_hist[6:0]), 64'b1101110);
        settle(3);
        chk("t1_drain", 64'(exp_q.size()), 64'd0);

        // Per-beat round robin with all four valid and no backpressure.
        for (int k = 0; k < 12; k++) fair_q.push_back(ent(k % 4, 32'hC0 + (k % 4)));
        fair_req = 1'b1;
        settle(12);
        fair_req = 1'b0;
        tick();
        chk("t2_drain", 64'(fair_q.size()), 64'd0);

        // Burst lock against a competitor that stays valid.
        remaining[0] = 6;
        next_val[0]  = 32'h100;
        remaining[1] = 8;
        next_val[1]  = 32'h200;
        for (int k = 0; k < 4; k++) exp_q.push_back(ent(0, 32'h100 + k));
        for (int k = 0; k < 4; k++) exp_q.push_back(ent(1, 32'h200 + k));
        for (int k = 4; k < 6; k++) exp_q.push_back(ent(0, 32'h100 + k));
        for (int k = 4; k < 8; k++) exp_q.push_back(ent(1, 32'h200 + k));
        run_until_idle(60, "t3_done");
        settle(3);
        chk("t3_drain", 64'(exp_q.size()), 64'd0);

        // Backpressure: depth-4 FIFO with reads stopped.
        start();
        rd_req = 1'b0;
        remaining[3] = 6;
        next_val[3]  = 32'h10;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(ent(3, 32'h10 + k));
            rd_exp_q.push_back(ent(3, 32'h10 + k));
        end
        settle(8);
        chk("t4_wren_hist", 64'(wren_hist[7:0]), 64'h0F);
        chk("t4_full", 64'(fifo_full), 64'd1);
        chk("t4_ready_full", 64'(req_ready), 64'd0);
        chk("t4_wren_full", 64'(fifo_wren), 64'd0);
        rd_chk = 1'b1;
        rd_req = 1'b1;
        run_until_idle(30, "t4_done");
        settle(4);
        chk("t4_rd_drain", 64'(rd_exp_q.size()), 64'd0);
        chk("t4_wr_drain", 64'(exp_q.size()), 64'd0);
        rd_chk = 1'b0;

        // Early release: owner drops valid after two beats, competitor waits one cycle.
        start();
        remaining[1] = 2;
        next_val[1]  = 32'h500;
        remaining[2] = 3;
        next_val[2]  = 32'h600;
        for (int k = 0; k < 2; k++) exp_q.push_back(ent(1, 32'h500 + k));
        for (int k = 0; k < 3; k++) exp_q.push_back(ent(2, 32'h600 + k));
        run_until_idle(30, "t5_done");
        chk("t5_wren_hist", 64'(wren_hist[5:0]), 64'b111011);
        chk("t5_busy_hist", 64'(busy_hist[5:0]), 64'b110110);
        settle(3);
        chk("t5_drain", 64'(exp_q.size()), 64'd0);

        // Reset in the third beat of a burst, then restart from requester 0.
        remaining[3] = 6;
        next_val[3]  = 32'h30;
        exp_q.push_back(ent(3, 32'h30));
        exp_q.push_back(ent(3, 32'h31));
        for (int k = 0; k < 3; k++) exp_q.push_back(ent(0, 32'h400 + k));
        for (int k = 2; k < 6; k++) exp_q.push_back(ent(3, 32'h30 + k));
        tick();
        tick();
        rst_req = 1'b0;
        tick();
        chk_reset_outputs("t6_rst");
        remaining[0] = 3;
        next_val[0]  = 32'h400;
        rst_req = 1'b1;
        run_until_idle(40, "t6_done");
        settle(3);
        chk("t6_drain", 64'(exp_q.size()), 64'd0);

        chk("no_overflow", 64'(overflow), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
